// File: rtl/object_transition_bound_pkg.sv
// Shared screen geometry, field widths and the saturating axis step used by the sprite mover.
package object_transition_bound_pkg;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int POS_X_W      = 10;
    localparam int POS_Y_W      = 9;
    localparam int ARITH_W      = 11;
    localparam int DIR_EN       = 1;
    localparam int DIR_POS      = 0;

    // Largest legal top-left coordinate; zero when the sprite is as large as the screen.
    function automatic logic [ARITH_W-1:0] axis_max(input logic [ARITH_W-1:0] extent,
                                                    input logic [ARITH_W-1:0] size);
        return (size >= extent) ? '0 : extent - size;
    endfunction

    // Clamping to max on both directions pulls an out-of-range start back on screen.
    function automatic logic [ARITH_W-1:0] sat_step(input logic [ARITH_W-1:0] pos,
                                                    input logic [ARITH_W-1:0] v,
                                                    input logic [ARITH_W-1:0] max,
                                                    input logic               sign);
        logic [ARITH_W-1:0] r;
        if (sign) r = pos + v;
        else      r = (pos < v) ? '0 : pos - v;
        if (r > max) r = max;
        return r;
    endfunction

endpackage

// File: rtl/object_edge_check.sv
// Registered edge-contact test for one axis: touches when at 0 or when the far side reaches the extent.
module object_edge_check
    import object_transition_bound_pkg::*;
#(
    parameter int EXTENT = 640,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] pos,
    input  logic [W-1:0] size,
    output logic         flag
);

    logic               flag_d;
    logic               flag_q;
    logic [ARITH_W-1:0] far_edge;

    always_comb begin
        far_edge = ARITH_W'(pos) + ARITH_W'(size);
        flag_d   = (pos == '0) | (far_edge >= ARITH_W'(EXTENT));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) flag_q <= 1'b0;
        else       flag_q <= flag_d;
    end

    assign flag = flag_q;

endmodule

// File: rtl/object_transition_bound.sv
// Sprite mover: synchronises the slow moveclk tick, steps a saturating x/y position and flags edge contact.
module object_transition_bound
    import object_transition_bound_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               moveclk,
    input  logic [POS_X_W-1:0] vx,
    input  logic [POS_Y_W-1:0] vy,
    input  logic [1:0]         dx,
    input  logic [1:0]         dy,
    input  logic [POS_X_W-1:0] initPosX,
    input  logic [POS_Y_W-1:0] initPosY,
    input  logic [POS_X_W-1:0] width,
    input  logic [POS_Y_W-1:0] height,
    output logic [POS_X_W-1:0] posx,
    output logic [POS_Y_W-1:0] posy,
    output logic               flag_out,
    output logic               flagx_out,
    output logic               flagy_out
);

    logic               m1_d, m2_d, m3_d;
    logic               m1_q, m2_q, m3_q;
    logic               tick;
    logic [POS_X_W-1:0] posx_d, posx_q;
    logic [POS_Y_W-1:0] posy_d, posy_q;
    logic [ARITH_W-1:0] xmax, ymax;

    // m1/m2 resynchronise moveclk; m3 delays m2 so the rising edge yields a one-cycle tick.
    always_comb begin
        m1_d = moveclk;
        m2_d = m1_q;
        m3_d = m2_q;
        tick = m2_q & ~m3_q;
    end

    always_comb begin
        xmax   = axis_max(ARITH_W'(SCREEN_W), ARITH_W'(width));
        ymax   = axis_max(ARITH_W'(SCREEN_H), ARITH_W'(height));
        posx_d = posx_q;
        posy_d = posy_q;
        if (tick && dx[DIR_EN])
            posx_d = POS_X_W'(sat_step(ARITH_W'(posx_q), ARITH_W'(vx), xmax, dx[DIR_POS]));
        if (tick && dy[DIR_EN])
            posy_d = POS_Y_W'(sat_step(ARITH_W'(posy_q), ARITH_W'(vy), ymax, dy[DIR_POS]));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m1_q   <= 1'b0;
            m2_q   <= 1'b0;
            m3_q   <= 1'b0;
            posx_q <= initPosX;
            posy_q <= initPosY;
        end else begin
            m1_q   <= m1_d;
            m2_q   <= m2_d;
            m3_q   <= m3_d;
            posx_q <= posx_d;
            posy_q <= posy_d;
        end
    end

    object_edge_check #(.EXTENT(SCREEN_W), .W(POS_X_W)) edge_x (
        .clk  (clk),
        .rstn (rstn),
        .pos  (posx_q),
        .size (width),
        .flag (flagx_out)
    );

    object_edge_check #(.EXTENT(SCREEN_H), .W(POS_Y_W)) edge_y (
        .clk  (clk),
        .rstn (rstn),
        .pos  (posy_q),
        .size (height),
        .flag (flagy_out)
    );

    assign posx     = posx_q;
    assign posy     = posy_q;
    assign flag_out = flagx_out | flagy_out;

endmodule

// File: tb/tb_object_transition_bound.sv
// Randomised and directed bench for the sprite mover against a plain-arithmetic position model.
module tb_object_transition_bound;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       moveclk = 1'b0;
    logic [9:0] vx = '0;
    logic [8:0] vy = '0;
    logic [1:0] dx = '0;
    logic [1:0] dy = '0;
    logic [9:0] initPosX = '0;
    logic [8:0] initPosY = '0;
    logic [9:0] width = '0;
    logic [8:0] height = '0;
    logic [9:0] posx;
    logic [8:0] posy;
    logic       flag_out, flagx_out, flagy_out;

    bit clk_en = 1'b0;
    int checks = 0;
    int errors = 0;
    int exp_x, exp_y;
    int saved_x, saved_y;

    always #5 if (clk_en) clk = ~clk;

    object_transition_bound dut (
        .clk       (clk),
        .rstn      (rstn),
        .moveclk   (moveclk),
        .vx        (vx),
        .vy        (vy),
        .dx        (dx),
        .dy        (dy),
        .initPosX  (initPosX),
        .initPosY  (initPosY),
        .width     (width),
        .height    (height),
        .posx      (posx),
        .posy      (posy),
        .flag_out  (flag_out),
        .flagx_out (flagx_out),
        .flagy_out (flagy_out)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_step(int pos, int v, int en, int sgn, int ext, int size);
        int mx, r;
        if (en == 0) return pos;
        mx = (size >= ext) ? 0 : ext - size;
        r  = (sgn != 0) ? pos + v : ((pos < v) ? 0 : pos - v);
        return (r > mx) ? mx : r;
    endfunction

    function automatic int model_flag(int pos, int size, int ext);
        return ((pos == 0) || (pos + size >= ext)) ? 1 : 0;
    endfunction

    task automatic do_reset(input int ix, input int iy);
        initPosX = 10'(ix);
        initPosY = 9'(iy);
        #1 rstn = 1'b0;
        #1;
        check_val("rst_posx", posx, ix);
        check_val("rst_posy", posy, iy);
        check_val("rst_flags", {flag_out, flagx_out, flagy_out}, 0);
        exp_x = ix;
        exp_y = iy;
        if (clk_en) @(negedge clk);
        rstn = 1'b1;
        if (clk_en) @(negedge clk);
    endtask

    task automatic do_tick(input bit chk_latency);
        int nx, ny, fx, fy;
        nx = model_step(exp_x, int'(vx), int'(dx[1]), int'(dx[0]), 640, int'(width));
        ny = model_step(exp_y, int'(vy), int'(dy[1]), int'(dy[0]), 480, int'(height));
        @(negedge clk);
        moveclk = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        if (chk_latency) check_val("pre_tick_posx", posx, exp_x);
        @(posedge clk);
        #1;
        exp_x = nx;
        exp_y = ny;
        check_val("tick_posx", posx, exp_x);
        check_val("tick_posy", posy, exp_y);
        @(posedge clk);
        #1;
        fx = model_flag(exp_x, int'(width), 640);
        fy = model_flag(exp_y, int'(height), 480);
        check_val("flagx", flagx_out, fx);
        check_val("flagy", flagy_out, fy);
        check_val("flag_or", flag_out, fx | fy);
        $display("tick dx=%b dy=%b vx=%0d vy=%0d w=%0d h=%0d -> pos=(%0d,%0d) flags=%b%b",
                 dx, dy, vx, vy, width, height, posx, posy, flagx_out, flagy_out);
        @(negedge clk);
        moveclk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Reset with the clock stopped.
        width = 10'd32; height = 9'd32;
        do_reset(100, 200);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Unit steps right, checking the three-edge latency each time.
        dx = 2'b11; vx = 10'd1; dy = 2'b00; vy = 9'd0;
        for (int i = 0; i < 5; i++) do_tick(1'b1);
        check_val("five_ticks_posx", posx, 105);

        // Leftward step saturating at 0.
        do_reset(3, 200);
        dx = 2'b10; vx = 10'd7;
        do_tick(1'b0);
        check_val("left_floor_posx", posx, 0);
        check_val("left_floor_flag", flag_out, 1);

        // Rightward clamp at 640-32, then hold.
        do_reset(600, 200);
        dx = 2'b11; vx = 10'd10;
        do_tick(1'b0);
        check_val("right_clamp_posx", posx, 608);
        do_tick(1'b0);
        check_val("right_hold_posx", posx, 608);

        // Corner: both axes reach their limits.
        width = 10'd40; height = 9'd40;
        do_reset(590, 440);
        dx = 2'b11; dy = 2'b11; vx = 10'd50; vy = 9'd50;
        do_tick(1'b0);
        check_val("corner_posx", posx, 600);
        check_val("corner_posy", posy, 440);
        check_val("corner_flags", {flagx_out, flagy_out}, 3);

        // Disabled axes hold over ten ticks.
        do_reset(123, 77);
        dx = 2'b01; dy = 2'b00;
        for (int i = 0; i < 10; i++) do_tick(1'b0);
        check_val("disabled_posx", posx, 123);
        check_val("disabled_posy", posy, 77);

        // Randomised motion with occasional re-initialisation, including out-of-range starts.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 14) == 0)
                do_reset(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
            width  = 10'($urandom_range(0, 700));
            height = 9'($urandom_range(0, 511));
            vx     = 10'($urandom_range(0, 90));
            vy     = 9'($urandom_range(0, 90));
            dx     = 2'($urandom_range(0, 3));
            dy     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) vx = 10'($urandom_range(0, 1023));
            do_tick(1'b0);
        end

        // Reset asserted mid-motion, between moveclk rise and the update.
        saved_x = 321; saved_y = 123;
        initPosX = 10'(saved_x); initPosY = 9'(saved_y);
        width = 10'd20; height = 9'd20;
        dx = 2'b11; vx = 10'd5;
        @(negedge clk);
        moveclk = 1'b1;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check_val("midrun_rst_posx", posx, saved_x);
        check_val("midrun_rst_posy", posy, saved_y);
        check_val("midrun_rst_flags", {flag_out, flagx_out, flagy_out}, 0);
        moveclk = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check_val("post_rst_hold_posx", posx, saved_x);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
